// File: rtl/numbers_pkg.sv
// Shared sizing helpers for the MAC and rounding datapath.
// Widths derived here keep producer and consumer stages in agreement.
package numbers_pkg;

    // Full-precision accumulator width: product width plus growth
    // for summing len products, so no overflow is possible.
    function automatic int acc_width(input int wa, input int wb, input int len);
        return wa + wb + $clog2(len);
    endfunction

    // Tap counter width; at least one bit even for a single tap.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered multiplier with valid/first/last frame sideband.
// Ports: clk, rst, hold (freeze all state), load (accept a sample),
//        in_a/in_b operands, prod/p_valid/p_first/p_last registered outputs.
module mac_mult_stage
    import numbers_pkg::*;
#(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int ACC_LEN   = 8,
    parameter int IS_SIGNED = 1,
    localparam int WIDTH_P  = WIDTH_A + WIDTH_B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               load,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    output logic [WIDTH_P-1:0] prod,
    output logic               p_valid,
    output logic               p_first,
    output logic               p_last
);

    localparam int CW = cnt_width(ACC_LEN);
    localparam logic [CW-1:0] LAST_TAP = CW'(ACC_LEN - 1);

    logic [WIDTH_P-1:0] prod_q, prod_d;
    logic               p_valid_q, p_valid_d;
    logic               p_first_q, p_first_d;
    logic               p_last_q, p_last_d;
    logic [CW-1:0]      tap_cnt_q, tap_cnt_d;
    logic [WIDTH_P-1:0] a_x, b_x;

    // Operands are extended to the product width so the low WIDTH_P
    // bits of the multiply are exact for both signed and unsigned use.
    always_comb begin
        if (IS_SIGNED != 0) begin
            a_x = {{WIDTH_B{in_a[WIDTH_A-1]}}, in_a};
            b_x = {{WIDTH_A{in_b[WIDTH_B-1]}}, in_b};
        end else begin
            a_x = {{WIDTH_B{1'b0}}, in_a};
            b_x = {{WIDTH_A{1'b0}}, in_b};
        end
    end

    always_comb begin
        prod_d    = prod_q;
        p_valid_d = p_valid_q;
        p_first_d = p_first_q;
        p_last_d  = p_last_q;
        tap_cnt_d = tap_cnt_q;
        if (!hold) begin
            if (load) begin
                prod_d    = a_x * b_x;
                p_valid_d = 1'b1;
                p_first_d = (tap_cnt_q == '0);
                p_last_d  = (tap_cnt_q == LAST_TAP);
                tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0
                                                    : tap_cnt_q + CW'(1);
            end else begin
                p_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q    <= '0;
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            tap_cnt_q <= '0;
        end else begin
            prod_q    <= prod_d;
            p_valid_q <= p_valid_d;
            p_first_q <= p_first_d;
            p_last_q  <= p_last_d;
            tap_cnt_q <= tap_cnt_d;
        end
    end

    assign prod    = prod_q;
    assign p_valid = p_valid_q;
    assign p_first = p_first_q;
    assign p_last  = p_last_q;

endmodule

// File: rtl/mac_accumulator.sv
// Pipelined multiply-accumulate: sums ACC_LEN products per result.
// Ports: clk, rst, ena, in_valid/in_ready/in_a/in_b sample input,
//        out_valid/out_ready/out_data full-precision result output.
module mac_accumulator
    import numbers_pkg::*;
#(
    parameter int WIDTH_A    = 16,
    parameter int WIDTH_B    = 16,
    parameter int ACC_LEN    = 8,
    parameter int IS_SIGNED  = 1,
    localparam int WIDTH_ACC = acc_width(WIDTH_A, WIDTH_B, ACC_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_A-1:0]   in_a,
    input  logic [WIDTH_B-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] out_data
);

    localparam int WIDTH_P = WIDTH_A + WIDTH_B;

    if (WIDTH_A <= 0) begin : g_chk_wa
        $error("mac_accumulator: WIDTH_A must be > 0, got %0d", WIDTH_A);
    end
    if (WIDTH_B <= 0) begin : g_chk_wb
        $error("mac_accumulator: WIDTH_B must be > 0, got %0d", WIDTH_B);
    end
    if (ACC_LEN < 1) begin : g_chk_len
        $error("mac_accumulator: ACC_LEN must be >= 1, got %0d", ACC_LEN);
    end

    logic [WIDTH_P-1:0]   prod;
    logic                 p_valid, p_first, p_last;
    logic                 stall, hold, acc_in, adv, out_fire;
    logic [WIDTH_ACC-1:0] prod_x, sum;
    logic [WIDTH_ACC-1:0] acc_q, acc_d;
    logic [WIDTH_ACC-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;

    // Only a finished sum blocked by a full output register stalls;
    // partial taps keep flowing into the accumulator.
    assign stall    = p_valid & p_last & out_valid_q & ~out_ready;
    assign in_ready = ~rst & ena & ~stall;
    assign acc_in   = in_valid & in_ready;
    assign hold     = ~ena | stall;
    assign adv      = ena & ~stall & p_valid;
    assign out_fire = out_valid_q & out_ready & ena;

    mac_mult_stage #(
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B),
        .ACC_LEN   (ACC_LEN),
        .IS_SIGNED (IS_SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .load    (acc_in),
        .in_a    (in_a),
        .in_b    (in_b),
        .prod    (prod),
        .p_valid (p_valid),
        .p_first (p_first),
        .p_last  (p_last)
    );

    always_comb begin
        if (IS_SIGNED != 0) begin
            prod_x = WIDTH_ACC'($signed(prod));
        end else begin
            prod_x = WIDTH_ACC'(prod);
        end
    end

    // First tap restarts the sum, so acc needs no clearing between frames.
    assign sum = p_first ? prod_x : acc_q + prod_x;

    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (adv) begin
            if (p_last) begin
                out_data_d  = sum;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator across three parameter sets.
// Defaults, signed 4x4 with ACC_LEN=4, and unsigned 8x8 with ACC_LEN=1.
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        ena0 = 1'b1, in_valid0 = 1'b0, in_ready0;
    logic [15:0] a0 = '0, b0 = '0;
    logic        out_valid0, out_ready0 = 1'b1;
    logic [34:0] out_data0;

    logic        ena1 = 1'b1, in_valid1 = 1'b0, in_ready1;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        out_valid1, out_ready1 = 1'b1;
    logic [9:0]  out_data1;

    logic        ena2 = 1'b1, in_valid2 = 1'b0, in_ready2;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        out_valid2, out_ready2 = 1'b1;
    logic [15:0] out_data2;

    mac_accumulator dut0 (
        .clk(clk), .rst(rst), .ena(ena0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(a0), .in_b(b0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0)
    );

    mac_accumulator #(
        .WIDTH_A(4), .WIDTH_B(4), .ACC_LEN(4), .IS_SIGNED(1)
    ) dut1 (
        .clk(clk), .rst(rst), .ena(ena1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(a1), .in_b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1)
    );

    mac_accumulator #(
        .WIDTH_A(8), .WIDTH_B(8), .ACC_LEN(1), .IS_SIGNED(0)
    ) dut2 (
        .clk(clk), .rst(rst), .ena(ena2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(a2), .in_b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_in_ready", 64'(in_ready0), 64'd0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_out_data", 64'(out_data0), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready0), 64'd1);

        // Two back-to-back frames: sum(1..8)*2=72, sum(1..8)*3=108
        for (int i = 0; i < 16; i++) begin
            a0 = 16'((i % 8) + 1);
            b0 = (i < 8) ? 16'd2 : 16'd3;
            in_valid0 = 1'b1;
            #1;
            if (in_ready0 !== 1'b1) chk("stream_in_ready", 64'(in_ready0), 64'd1);
            step();
            if (i == 8) begin
                chk("f1_valid", 64'(out_valid0), 64'd1);
                chk("f1_data", 64'(out_data0), 64'd72);
            end
            if (i == 9) chk("f1_pulse_end", 64'(out_valid0), 64'd0);
        end
        in_valid0 = 1'b0;
        step();
        chk("f2_valid", 64'(out_valid0), 64'd1);
        chk("f2_data", 64'(out_data0), 64'd108);
        step();
        chk("f2_drained", 64'(out_valid0), 64'd0);

        // Backpressure through two frames: 8 then 16
        out_ready0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a0 = (i < 8) ? 16'd1 : 16'd2;
            b0 = 16'd1;
            in_valid0 = 1'b1;
            #1;
            if (in_ready0 !== 1'b1) chk("bp_in_ready", 64'(in_ready0), 64'd1);
            step();
            if (i == 8) chk("bp_first_data", 64'(out_data0), 64'd8);
        end
        in_valid0 = 1'b0;
        #1;
        chk("bp_stall_ready", 64'(in_ready0), 64'd0);
        chk("bp_hold_valid", 64'(out_valid0), 64'd1);
        chk("bp_hold_data", 64'(out_data0), 64'd8);
        step();
        chk("bp_hold_data2", 64'(out_data0), 64'd8);
        chk("bp_stall_ready2", 64'(in_ready0), 64'd0);
        out_ready0 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready0), 64'd1);
        step();
        chk("drain_load_valid", 64'(out_valid0), 64'd1);
        chk("drain_load_data", 64'(out_data0), 64'd16);
        step();
        chk("bp_drained", 64'(out_valid0), 64'd0);

        // Reset after 3 of 8 taps discards the partial sum
        for (int i = 0; i < 3; i++) begin
            a0 = 16'd5;
            b0 = 16'd5;
            in_valid0 = 1'b1;
            step();
        end
        in_valid0 = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(out_valid0), 64'd0);
        chk("mid_rst_data", 64'(out_data0), 64'd0);
        chk("mid_rst_ready", 64'(in_ready0), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a0 = 16'd1;
            b0 = 16'd1;
            in_valid0 = 1'b1;
            step();
        end
        in_valid0 = 1'b0;
        step();
        chk("after_rst_valid", 64'(out_valid0), 64'd1);
        chk("after_rst_data", 64'(out_data0), 64'd8);

        // Signed extremes: (-8)(-8)x4=256, (-8)(7)x4=-224 (800 mod 1024)
        for (int i = 0; i < 8; i++) begin
            a1 = 4'h8;
            b1 = (i < 4) ? 4'h8 : 4'h7;
            in_valid1 = 1'b1;
            step();
            if (i == 4) begin
                chk("s_pos_valid", 64'(out_valid1), 64'd1);
                chk("s_pos_data", 64'(out_data1), 64'd256);
            end
        end
        in_valid1 = 1'b0;
        step();
        chk("s_neg_valid", 64'(out_valid1), 64'd1);
        chk("s_neg_data", 64'(out_data1), 64'd800);

        // ACC_LEN=1 unsigned, with ena low for three cycles
        a2 = 8'd255;
        b2 = 8'd255;
        in_valid2 = 1'b1;
        step();
        a2 = 8'd3;
        b2 = 8'd4;
        step();
        chk("u_valid", 64'(out_valid2), 64'd1);
        chk("u_data", 64'(out_data2), 64'd65025);
        ena2 = 1'b0;
        a2 = 8'd1;
        b2 = 8'd1;
        #1;
        chk("ena_in_ready", 64'(in_ready2), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ena_freeze_data", 64'(out_data2), 64'd65025);
            chk("ena_freeze_valid", 64'(out_valid2), 64'd1);
        end
        ena2 = 1'b1;
        step();
        chk("ena_resume_data", 64'(out_data2), 64'd12);
        in_valid2 = 1'b0;
        step();
        chk("u_last_data", 64'(out_data2), 64'd1);
        step();
        chk("u_drained", 64'(out_valid2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
